pdm_mic_rx: RTL and testbench

- Audio-input counterpart to the PWM audio-output path. It clocks the board PDM microphone (M_CLK/M_DATA) and samples its 1-bit stream.
- It decimates the stream with a boxcar ones-counter into 11-bit unsigned samples, in the same 0..2047 format and 1024 midscale that the PWM player consumes.
- It emits each sample with a 1-cycle valid strobe for a capture BRAM writer or direct loopback into PWM.
- It also provides a 3-bit peak level meter for the LEDs.

---
 rtl/pdm_mic_rx.sv | 90 +++++++++
 tb/tb_pdm_mic_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: drives the PDM microphone clock and boxcar-decimates its bit stream
// into 11-bit unsigned samples (midscale 1024), with a windowed peak level meter.
module pdm_mic_rx #(
    parameter int CLK_HALF = 25,
    parameter int DECIM    = 128,
    parameter int PEAK_WIN = 64
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        en,
    input  logic        M_DATA,
    output logic        M_CLK,
    output logic        M_LRSEL,
    output logic [10:0] sample,
    output logic        sample_valid,
    output logic [2:0]  level
);
    localparam int DW = $clog2(CLK_HALF + 1);
    localparam int BW = $clog2(DECIM);
    localparam int WW = $clog2(PEAK_WIN + 1);
    localparam int SH = 11 - BW;

    logic          m_meta, m_sync;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW:0]   ones, total;
    logic [9:0]    peak, mag, pk;
    logic [WW-1:0] win_cnt;
    logic [11:0]   scaled;
    logic [10:0]   sample_new, diff;
    logic          tick, capture, last, win_last;

    assign M_LRSEL = 1'b0;

    always_comb begin
        tick       = div_cnt == DW'(CLK_HALF - 1);
        capture    = tick && M_CLK;
        last       = capture && bit_cnt == BW'(DECIM - 1);
        total      = ones + (BW+1)'(m_sync);
        scaled     = 12'(total) << SH;
        sample_new = scaled[11] ? 11'd2047 : scaled[10:0];
        // 1024 - 0 does not fit the 10-bit magnitude, so clamp it to full scale
        diff       = sample_new[10] ? {1'b0, sample_new[9:0]} : 11'd1024 - sample_new;
        mag        = diff[10] ? 10'd1023 : diff[9:0];
        pk         = mag > peak ? mag : peak;
        win_last   = win_cnt == WW'(PEAK_WIN - 1);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            m_meta       <= 1'b0;
            m_sync       <= 1'b0;
            M_CLK        <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            ones         <= '0;
            peak         <= '0;
            win_cnt      <= '0;
            sample       <= 11'd1024;
            sample_valid <= 1'b0;
            level        <= '0;
        end else begin
            m_meta       <= M_DATA;
            m_sync       <= m_meta;
            sample_valid <= en && last;
            if (!en) begin
                M_CLK   <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                ones    <= '0;
                peak    <= '0;
                win_cnt <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) M_CLK <= !M_CLK;
                // bit_cnt wraps to 0 on its own because DECIM is a power of two
                if (capture) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    ones    <= last ? '0 : total;
                end
                if (last) begin
                    sample  <= sample_new;
                    peak    <= win_last ? '0 : pk;
                    win_cnt <= win_last ? '0 : win_cnt + 1'b1;
                    if (win_last) level <= pk[9:7];
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_mic_rx.sv
// tb_pdm_mic_rx: directed checks of clocking, decimation, reset/enable restarts
// and the level meter (second instance with a short meter window).
module tb_pdm_mic_rx;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, d1 = 1'b0, d2 = 1'b0;
    logic        mclk1, lr1, sv1, mclk2, lr2, sv2;
    logic [10:0] s1, s2;
    logic [2:0]  l1, l2;
    int          errs = 0, checks = 0, cyc = 0, nm1 = 0;
    logic        done2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pdm_mic_rx dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en), .M_DATA(d1),
        .M_CLK(mclk1), .M_LRSEL(lr1), .sample(s1), .sample_valid(sv1), .level(l1)
    );

    pdm_mic_rx #(.CLK_HALF(2), .DECIM(16), .PEAK_WIN(4)) dut2 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en), .M_DATA(d2),
        .M_CLK(mclk2), .M_LRSEL(lr2), .sample(s2), .sample_valid(sv2), .level(l2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic pat(input int m, input int b);
        case (m)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (b % 2) == 0;
            default: return b < 32;
        endcase
    endfunction

    function automatic int wcnt(input int w);
        case (w)
            0:       return 8;
            1:       return 9;
            2:       return 16;
            3:       return 7;
            default: return 8;
        endcase
    endfunction

    // Data drivers: advance one bit after each observed M_CLK fall (capture)
    initial begin
        int   bi = 0, cm = 0;
        logic mp = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !en) begin
                bi = 0;
                cm = nm1;
            end else if (mp && !mclk1) begin
                bi++;
                if (bi == 128) begin
                    bi = 0;
                    cm = nm1;
                end
            end
            mp = mclk1;
            d1 = pat(cm, bi);
        end
    end

    initial begin
        int   bi = 0, wi = 0;
        logic mp = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !en) begin
                bi = 0;
                wi = 0;
            end else if (mp && !mclk2) begin
                bi++;
                if (bi == 16) begin
                    bi = 0;
                    wi++;
                end
            end
            mp = mclk2;
            d2 = bi < wcnt(wi);
        end
    end

    // Level meter instance: window 1024,1152,2047,896 then four 1024 samples
    initial begin
        logic [10:0] es[8] = '{11'd1024, 11'd1152, 11'd2047, 11'd896,
                               11'd1024, 11'd1024, 11'd1024, 11'd1024};
        int          el[8] = '{0, 0, 0, 7, 7, 7, 7, 0};
        int          n;
        @(posedge rst_n);
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!sv2 && n < 200);
            check($sformatf("meter strobe %0d seen", k), n < 200, 1);
            check($sformatf("meter sample %0d", k), s2, es[k]);
            check($sformatf("meter level %0d", k), l2, el[k]);
        end
        done2 = 1'b1;
    end

    task automatic wait_strobe(input int c0, output int lat);
        do @(negedge clk); while (!sv1 && cyc - c0 < 7000);
        lat = cyc - c0;
    endtask

    task automatic wait_caps(input int n);
        logic p = mclk1;
        int   k = 0, t = 0;
        while (k < n && t < n * 60 + 100) begin
            @(negedge clk);
            t++;
            if (p && !mclk1) k++;
            p = mclk1;
        end
        check("capture count reached", k, n);
    endtask

    task automatic strobe_checks(input string tag, input int c0, input int lat_exp, input int s_exp, output int ts);
        int lat;
        wait_strobe(c0, lat);
        ts = cyc;
        check({tag, " latency"}, lat, lat_exp);
        check({tag, " sample"}, s1, s_exp);
        @(negedge clk);
        check({tag, " strobe width"}, sv1, 0);
    endtask

    initial begin
        int c0, c1, ts, bad;
        rst_n = 1'b0;
        en    = 1'b1;
        nm1   = 0;
        repeat (5) @(negedge clk);
        check("reset M_CLK", mclk1, 0);
        check("reset sample", s1, 1024);
        check("reset sample_valid", sv1, 0);
        check("reset level", l1, 0);
        check("M_LRSEL", lr1, 0);
        rst_n = 1'b1;
        c0 = cyc;
        do @(negedge clk); while (!mclk1 && cyc - c0 < 100);
        check("first M_CLK rise", cyc - c0, 25);
        c1 = cyc;
        do @(negedge clk); while (mclk1 && cyc - c1 < 100);
        check("M_CLK high time", cyc - c1, 25);
        c1 = cyc;
        do @(negedge clk); while (!mclk1 && cyc - c1 < 100);
        check("M_CLK low time", cyc - c1, 25);

        strobe_checks("ones first", c0, 6400, 2047, ts);
        nm1 = 1;
        strobe_checks("ones period", ts, 6400, 2047, ts);
        nm1 = 2;
        strobe_checks("zeros", ts, 6400, 0, ts);
        nm1 = 3;
        strobe_checks("alternating", ts, 6400, 1024, ts);
        nm1 = 0;
        strobe_checks("quarter", ts, 6400, 512, ts);

        wait_caps(60);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-window reset sample", s1, 1024);
        check("mid-window reset valid", sv1, 0);
        rst_n = 1'b1;
        c0 = cyc;
        strobe_checks("after reset", c0, 6400, 2047, ts);

        nm1 = 2;
        wait_caps(40);
        en  = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (mclk1 || sv1 || s1 != 11'd2047) bad++;
        end
        check("disabled hold cycles bad", bad, 0);
        en = 1'b1;
        c0 = cyc;
        strobe_checks("after enable", c0, 6400, 1024, ts);

        c1 = cyc;
        while (!done2 && cyc - c1 < 1000) @(negedge clk);
        check("meter checks done", done2, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
